// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - instruction memory read request/response bundle
interface fetch_ctrl_if;
   logic        imem_read;
   logic [31:0] imem_addr;
   logic        imem_resp;
   logic [31:0] imem_rdata;

   modport master (
      output imem_read,
      output imem_addr,
      input  imem_resp,
      input  imem_rdata
   );

   modport slave (
      input  imem_read,
      input  imem_addr,
      output imem_resp,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch sequencer with one-entry IF/ID buffer and redirect squash
module fetch_ctrl #(
   parameter int TIMEOUT = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [31:0]         pc,
   output logic                load_pc,
   output logic [1:0]          pcmux_sel,
   fetch_ctrl_if.master        imem,
   input  logic                br_taken,
   input  logic                jalr_taken,
   input  logic                stall,
   output logic                if_valid,
   output logic [31:0]         if_instr,
   output logic [31:0]         if_pc,
   output logic                flush,
   output logic                timeout_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      FETCH = 2'b01,
      HOLD  = 2'b10
   } state_t;

   localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

   state_t      state;
   logic        read_q;
   logic [31:0] addr_q;
   logic        discard;
   logic [15:0] wdog;
   logic [15:0] wdog_inc;

   logic redirect;
   logic buf_free;
   logic accept;

   assign imem.imem_read = read_q;
   assign imem.imem_addr = addr_q;

   // Redirect and accepted-response decode; gated so nothing leaks out during reset
   always_comb begin
      redirect  = !rst && (br_taken || jalr_taken);
      buf_free  = !if_valid || !stall;
      accept    = !rst && (state == FETCH) && imem.imem_resp && !redirect
                  && !discard && buf_free;
      load_pc   = redirect || accept;
      flush     = redirect;
      pcmux_sel = 2'b00;
      if (redirect) begin
         pcmux_sel = jalr_taken ? 2'b10 : 2'b01;
      end
   end

   assign wdog_inc = (wdog == 16'hFFFF) ? wdog : wdog + 16'd1;

   // Fetch sequencer: request issue, stale-response squash, and back-pressure hold
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         read_q  <= 1'b0;
         addr_q  <= 32'd0;
         discard <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // A redirect here means pc is about to change; latch it next cycle
               if (!redirect) begin
                  addr_q <= pc;
                  state  <= FETCH;
                  read_q <= 1'b1;
               end
            end
            FETCH: begin
               if (imem.imem_resp && (redirect || discard)) begin
                  discard <= 1'b0;
                  state   <= IDLE;
                  read_q  <= 1'b0;
               end else if (redirect) begin
                  // The in-flight request cannot be cancelled; remember to drop it
                  discard <= 1'b1;
               end else if (imem.imem_resp) begin
                  if (buf_free) begin
                     addr_q <= addr_q + 32'd4;
                  end else begin
                     state  <= HOLD;
                     read_q <= 1'b0;
                  end
               end
            end
            HOLD: begin
               if (redirect) begin
                  state <= IDLE;
               end else if (!stall) begin
                  state  <= FETCH;
                  read_q <= 1'b1;
               end
            end
            default: begin
               state  <= IDLE;
               read_q <= 1'b0;
            end
         endcase
      end
   end

   // One-entry fetch buffer feeding IF/ID
   always_ff @(posedge clk) begin
      if (rst) begin
         if_valid <= 1'b0;
         if_instr <= 32'd0;
         if_pc    <= 32'd0;
      end else if (redirect) begin
         if_valid <= 1'b0;
      end else if (accept) begin
         if_valid <= 1'b1;
         if_instr <= imem.imem_rdata;
         if_pc    <= addr_q;
      end else if (if_valid && !stall) begin
         if_valid <= 1'b0;
      end
   end

   // Watchdog on response latency; the error is sticky and purely informational
   always_ff @(posedge clk) begin
      if (rst) begin
         wdog        <= 16'd0;
         timeout_err <= 1'b0;
      end else if (state == FETCH && !imem.imem_resp) begin
         wdog <= wdog_inc;
         if (TIMEOUT != 0 && wdog_inc >= TIMEOUT_W) begin
            timeout_err <= 1'b1;
         end
      end else begin
         wdog <= 16'd0;
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - randomized and directed bench for fetch_ctrl against a fetch-stream model
module tb_fetch_ctrl;
   localparam int TIMEOUT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc;
   logic        load_pc;
   logic [1:0]  pcmux_sel;
   logic        br_taken;
   logic        jalr_taken;
   logic        stall;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        flush;
   logic        timeout_err;

   fetch_ctrl_if imem();

   fetch_ctrl #(.TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst         (rst),
      .pc          (pc),
      .load_pc     (load_pc),
      .pcmux_sel   (pcmux_sel),
      .imem        (imem),
      .br_taken    (br_taken),
      .jalr_taken  (jalr_taken),
      .stall       (stall),
      .if_valid    (if_valid),
      .if_instr    (if_instr),
      .if_pc       (if_pc),
      .flush       (flush),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Reference model of the fetch stream
   bit          m_fetching, m_holding, m_stale, m_bv, m_err;
   logic [31:0] m_addr, m_bi, m_bp, m_pc;
   int          m_wd;
   int          wait_left, next_lat;
   bit          mem_hold, stray_en;
   logic [31:0] alu_out, alu_mod2;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_fetching = 0; m_holding = 0; m_stale = 0; m_bv = 0; m_err = 0;
      m_addr = 0; m_bi = 0; m_bp = 0; m_wd = 0; wait_left = 0;
   endtask

   task automatic tick();
      bit          redir, bfree, accept, e_load, resp, was_f, was_h;
      logic [1:0]  e_sel;
      logic [31:0] old_addr, npc;
      pc = m_pc;
      resp = 0;
      if (!rst && m_fetching && !mem_hold && wait_left == 0) resp = 1;
      else if (stray_en && !m_fetching && $urandom_range(3) == 0) resp = 1;
      imem.imem_resp  = resp;
      imem.imem_rdata = (resp && m_fetching) ? instr_of(m_addr) : $urandom;
      #1;
      redir  = !rst && (br_taken || jalr_taken);
      bfree  = !m_bv || !stall;
      accept = !rst && m_fetching && resp && !redir && !m_stale && bfree;
      e_load = redir || accept;
      e_sel  = !redir ? 2'd0 : (jalr_taken ? 2'd2 : 2'd1);
      chk("load_pc", 32'(load_pc), 32'(e_load));
      chk("pcmux_sel", 32'(pcmux_sel), 32'(e_sel));
      chk("flush", 32'(flush), 32'(redir));
      chk("imem_read", 32'(imem.imem_read), 32'(m_fetching));
      chk("imem_addr", imem.imem_addr, m_addr);
      chk("if_valid", 32'(if_valid), 32'(m_bv));
      chk("if_instr", if_instr, m_bi);
      chk("if_pc", if_pc, m_bp);
      chk("timeout_err", 32'(timeout_err), 32'(m_err));
      if (!rst && m_fetching && !m_stale) chk("pc_eq_addr", imem.imem_addr, pc);
      @(posedge clk);
      #1;
      if (rst) begin
         model_reset();
      end else begin
         was_f    = m_fetching;
         was_h    = m_holding;
         old_addr = m_addr;
         npc      = m_pc;
         if (e_load) npc = (e_sel == 2'd0) ? m_pc + 32'd4 : (e_sel == 2'd1) ? alu_out : alu_mod2;
         if (!was_f && !was_h) begin
            if (!redir) begin
               m_addr = m_pc;
               m_fetching = 1;
            end
         end else if (was_f) begin
            if (resp) m_wd = 0;
            else begin
               m_wd++;
               if (TIMEOUT != 0 && m_wd >= TIMEOUT) m_err = 1;
            end
            if (resp && (redir || m_stale)) begin
               m_stale = 0;
               m_fetching = 0;
            end else if (redir) begin
               m_stale = 1;
            end else if (resp) begin
               if (bfree) m_addr = m_addr + 32'd4;
               else begin
                  m_fetching = 0;
                  m_holding = 1;
               end
            end
         end else begin
            if (redir) m_holding = 0;
            else if (!stall) begin
               m_holding = 0;
               m_fetching = 1;
            end
         end
         if (!m_fetching) m_wd = 0;
         if (redir) m_bv = 0;
         else if (accept) begin
            m_bv = 1;
            m_bi = instr_of(old_addr);
            m_bp = old_addr;
         end else if (m_bv && !stall) m_bv = 0;
         if (m_fetching && (!was_f || resp)) wait_left = next_lat;
         else if (m_fetching && wait_left > 0) wait_left--;
         m_pc = npc;
      end
      pc = m_pc;
      @(negedge clk);
   endtask

   initial begin
      rst = 1; br_taken = 0; jalr_taken = 0; stall = 0;
      mem_hold = 0; stray_en = 0; next_lat = 0;
      alu_out = 32'h200; alu_mod2 = 32'h300;
      m_pc = 32'h60; pc = m_pc;
      imem.imem_resp = 0; imem.imem_rdata = 0;
      model_reset();
      @(negedge clk);

      // reset holds everything at zero
      tick(); tick();
      rst = 0;

      // zero-wait streaming from 0x60
      repeat (6) tick();

      // back-pressure while the buffer is full, then release
      stall = 1;
      repeat (3) tick();
      stall = 0;
      repeat (3) tick();

      // branch at the first cycle of a three-cycle fetch
      next_lat = 2;
      for (int i = 0; i < 20 && !(m_fetching && !m_stale && wait_left == 2); i++) tick();
      chk("sync_br_budget", 32'(m_fetching && wait_left == 2), 32'd1);
      br_taken = 1;
      tick();
      br_taken = 0;
      repeat (6) tick();

      // JALR and branch together, coincident with a response
      next_lat = 0;
      alu_mod2 = 32'h400;
      for (int i = 0; i < 20 && !(m_fetching && !m_stale && wait_left == 0); i++) tick();
      chk("sync_jalr_budget", 32'(m_fetching && wait_left == 0), 32'd1);
      br_taken = 1; jalr_taken = 1;
      tick();
      br_taken = 0; jalr_taken = 0;
      repeat (4) tick();

      // randomized traffic with stray responses
      stray_en = 1;
      for (int i = 0; i < 400; i++) begin
         stall      = ($urandom_range(3) == 0);
         br_taken   = ($urandom_range(15) == 0);
         jalr_taken = ($urandom_range(19) == 0);
         next_lat   = $urandom_range(2);
         alu_out    = $urandom & 32'hFFFF_FFFC;
         alu_mod2   = $urandom & 32'hFFFF_FFFC;
         tick();
      end
      stall = 0; br_taken = 0; jalr_taken = 0; stray_en = 0; next_lat = 0;

      // watchdog with responses withheld, then reset mid-fetch
      mem_hold = 1;
      repeat (9) tick();
      chk("timeout_reached", 32'(m_err), 32'd1);
      rst = 1;
      tick();
      rst = 0;
      repeat (2) tick();
      mem_hold = 0;
      repeat (4) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
